// File: rtl/msk_rnd_pkg.sv
// Shared constants for the HPC2 randomness source: share count, LFSR taps,
// controller state encoding and the HPC2 random-bit count.
package msk_rnd_pkg;

  localparam int DEFAULTSHARES = 2;

  // x^31 + x^28 + 1: feedback taps are state bits 30 and 27
  localparam int LFSR_LEN    = 31;
  localparam int LFSR_TAP_HI = 31;
  localparam int LFSR_TAP_LO = 28;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEED = 2'd1;
  localparam logic [1:0] ST_WARM = 2'd2;
  localparam logic [1:0] ST_RUN  = 2'd3;

  // Same definition the HPC2 gadgets use for their rnd port width.
  function automatic int hpc2rnd_of(input int shares);
    return shares * (shares - 1) / 2;
  endfunction

endpackage

// File: rtl/msk_lfsr31_lane.sv
// One 31-bit Fibonacci LFSR lane with load, step and hold; the MSB is the output bit.
module msk_lfsr31_lane
  import msk_rnd_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_en,
  input  logic                step_en,
  input  logic [LFSR_LEN-1:0] load_val,
  output logic                rnd_bit
);

  logic [LFSR_LEN-1:0] lfsr_q, lfsr_d;
  logic                feedback;

  assign feedback = lfsr_q[LFSR_TAP_HI-1] ^ lfsr_q[LFSR_TAP_LO-1];

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_en) begin
      // all-zero is the lock-up state of this LFSR, so it is never loaded
      lfsr_d = (load_val == '0) ? LFSR_LEN'(1) : load_val;
    end else if (step_en) begin
      lfsr_d = {lfsr_q[LFSR_LEN-2:0], feedback};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= LFSR_LEN'(1);
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign rnd_bit = lfsr_q[LFSR_LEN-1];

endmodule

// File: rtl/msk_rnd_source_hpc2.sv
// Randomness source for HPC2 gadget arrays: serially seeded LFSR lanes,
// warm-up after each seed, then one fresh word per consumed cycle.
module msk_rnd_source_hpc2
  import msk_rnd_pkg::*;
#(
  parameter  int d       = DEFAULTSHARES,
  parameter  int WARMUP  = 64,
  localparam int HPC2RND = hpc2rnd_of(d)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        seed_in,
  input  logic               seed_valid,
  output logic               seed_ready,
  output logic [HPC2RND-1:0] rnd_out,
  output logic               rnd_valid,
  input  logic               rnd_ready,
  output logic               busy
);

  localparam int CNT_W  = (HPC2RND > 1) ? $clog2(HPC2RND + 1) : 1;
  localparam int WARM_W = $clog2(WARMUP + 1);

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WARM_W-1:0]  warm_q, warm_d;
  logic               seed_fire;
  logic               step_en;
  logic [HPC2RND-1:0] load_en;

  // Outputs decode state only, so no input reaches an output combinationally.
  assign seed_ready = (state_q != ST_WARM);
  assign rnd_valid  = (state_q == ST_RUN);
  assign busy       = (state_q == ST_SEED) || (state_q == ST_WARM);
  assign seed_fire  = seed_valid && seed_ready;

  // A reseed beat in RUN overwrites lane 0, so that cycle never steps.
  assign step_en = (state_q == ST_WARM) ||
                   ((state_q == ST_RUN) && rnd_ready && !seed_fire);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    warm_d  = warm_q;
    case (state_q)
      ST_IDLE, ST_RUN: begin
        if (seed_fire) begin
          if (HPC2RND == 1) begin
            state_d = ST_WARM;
            warm_d  = '0;
          end else begin
            state_d = ST_SEED;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      ST_SEED: begin
        if (seed_fire) begin
          if (cnt_q == CNT_W'(HPC2RND - 1)) begin
            state_d = ST_WARM;
            cnt_d   = '0;
            warm_d  = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        if (warm_q == WARM_W'(WARMUP - 1)) begin
          state_d = ST_RUN;
          warm_d  = '0;
        end else begin
          warm_d = warm_q + WARM_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      warm_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      warm_q  <= warm_d;
    end
  end

  generate
    for (genvar gi = 0; gi < HPC2RND; gi++) begin : g_lane
      // Lane 0 is loaded by the first beat (from IDLE or RUN), others by the lane counter.
      assign load_en[gi] = seed_fire &&
          (((gi == 0) && ((state_q == ST_IDLE) || (state_q == ST_RUN))) ||
           ((state_q == ST_SEED) && (cnt_q == CNT_W'(gi))));

      msk_lfsr31_lane u_lane (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_en  (load_en[gi]),
        .step_en  (step_en),
        .load_val (seed_in[LFSR_LEN-1:0]),
        .rnd_bit  (rnd_out[gi])
      );
    end
  endgenerate

endmodule
